fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined datapath.
- Owns the program counter and drives the word address of the asynchronous-read instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles stall and flush from hazard control, branch/jump redirect from ID, and halt detection.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/if_id_reg.sv | 36 +++
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch stage and IF/ID register.
// Holds the fetch FSM state type, PC step size and IF/ID bubble values.
package pipe_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] BUBBLE_INSTR = NOP_WORD;
    localparam logic [31:0] BUBBLE_PC4   = 32'h0000_0000;
    localparam logic        BUBBLE_VALID = 1'b0;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
// Ports: clk, reset (async high), load, bubble, instr_in/pc4_in in; instr/pc4/valid out.
import pipe_pkg::*;

module if_id_reg #(
    parameter int dataWidth = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 bubble,
    input  logic [dataWidth-1:0] instr_in,
    input  logic [dataWidth-1:0] pc4_in,
    output logic [dataWidth-1:0] instr,
    output logic [dataWidth-1:0] pc4,
    output logic                 valid
);

    // bubble wins over load; neither asserted means hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= dataWidth'(BUBBLE_INSTR);
            pc4   <= dataWidth'(BUBBLE_PC4);
            valid <= BUBBLE_VALID;
        end else if (bubble) begin
            instr <= dataWidth'(BUBBLE_INSTR);
            pc4   <= dataWidth'(BUBBLE_PC4);
            valid <= BUBBLE_VALID;
        end else if (load) begin
            instr <= instr_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, run/halt FSM, fetch counter, IF/ID register.
// Ports: clk, reset, stall, flush, redirect(+pc), imem_addr/imem_data, IF/ID outs, pc, halted, fetch_count.
import pipe_pkg::*;

module fetch_stage #(
    parameter int                 addWidth  = 6,
    parameter int                 dataWidth = 32,
    parameter logic [dataWidth-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [dataWidth-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redirect,
    input  logic [dataWidth-1:0] redirect_pc,
    output logic [addWidth-1:0]  imem_addr,
    input  logic [dataWidth-1:0] imem_data,
    output logic [dataWidth-1:0] if_id_instr,
    output logic [dataWidth-1:0] if_id_pc4,
    output logic                 if_id_valid,
    output logic [dataWidth-1:0] pc,
    output logic                 halted,
    output logic [31:0]          fetch_count
);

    fetch_state_t         state;
    logic [dataWidth-1:0] pc_next;
    logic [dataWidth-1:0] target;
    logic                 is_halt;
    logic                 load;
    logic                 bubble;
    logic                 unused_bits;

    assign imem_addr = pc[addWidth+1:2];
    assign pc_next   = pc + dataWidth'(PC_STEP);
    assign target    = {redirect_pc[dataWidth-1:2], 2'b00};
    assign is_halt   = (imem_data == HALT_WORD);

    assign unused_bits = ^{redirect_pc[1:0], pc[1:0],
                           pc[dataWidth-1:addWidth+2]};

    // IF/ID control follows the same priority as the PC update below
    always_comb begin
        load   = 1'b0;
        bubble = 1'b0;
        if (state == HALT) begin
            bubble = 1'b1;
        end else if (redirect) begin
            bubble = 1'b1;
        end else if (stall) begin
            bubble = flush;
        end else if (is_halt || flush) begin
            bubble = 1'b1;
        end else begin
            load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            halted      <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (redirect) begin
                        pc <= target;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (is_halt) begin
                        state <= HALT;
                    end else if (flush) begin
                        pc <= pc_next;
                    end else begin
                        pc          <= pc_next;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                HALT: begin
                    // halted rises one edge after entering HALT
                    if (redirect) begin
                        pc     <= target;
                        state  <= RUN;
                        halted <= 1'b0;
                    end else begin
                        halted <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    if_id_reg #(
        .dataWidth(dataWidth)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .bubble  (bubble),
        .instr_in(imem_data),
        .pc4_in  (pc_next),
        .instr   (if_id_instr),
        .pc4     (if_id_pc4),
        .valid   (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios and random
// stall/flush/redirect traffic against a behavioural fetch model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid, m_in_halt, m_halted;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .if_id_instr(if_id_instr),
        .if_id_pc4  (if_id_pc4),
        .if_id_valid(if_id_valid),
        .pc         (pc),
        .halted     (halted),
        .fetch_count(fetch_count)
    );

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_cnt = 0;
        m_valid = 0; m_in_halt = 0; m_halted = 0;
    endtask

    task automatic model_bubble();
        m_instr = 0; m_pc4 = 0; m_valid = 0;
    endtask

    // one clock edge of fetch behaviour, from the rules in priority order
    task automatic model_edge();
        logic [31:0] w;
        w = mem[m_pc[7:2]];
        if (m_in_halt) begin
            model_bubble();
            if (redirect) begin
                m_pc = redirect_pc & ~32'd3;
                m_in_halt = 0;
                m_halted = 0;
            end else begin
                m_halted = 1;
            end
        end else if (redirect) begin
            m_pc = redirect_pc & ~32'd3;
            model_bubble();
        end else if (stall) begin
            if (flush) model_bubble();
        end else if (w == 32'hFFFF_FFFF) begin
            model_bubble();
            m_in_halt = 1;
        end else if (flush) begin
            m_pc = m_pc + 4;
            model_bubble();
        end else begin
            m_instr = w;
            m_pc4 = m_pc + 4;
            m_valid = 1;
            m_cnt = m_cnt + 1;
            m_pc = m_pc + 4;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #2 reset = 0;
        model_reset();
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h11 * (i + 1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 32'h0) begin
            errors++; $display("FAIL reset_pc got %h want 0", pc);
        end
        checks++;
        if ({if_id_instr, if_id_pc4, if_id_valid} !== 65'h0) begin
            errors++;
            $display("FAIL reset_ifid got %h/%h/%b want 0", if_id_instr, if_id_pc4, if_id_valid);
        end
        checks++;
        if (halted !== 1'b0 || fetch_count !== 32'h0 || imem_addr !== 6'h0) begin
            errors++;
            $display("FAIL reset_misc got h=%b c=%0d a=%0d want 0", halted, fetch_count, imem_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (pc !== 32'(4 * k) || if_id_instr !== 32'(32'h11 * k) ||
                if_id_pc4 !== 32'(4 * k) || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq%0d got pc=%h i=%h p4=%h v=%b want pc=%h i=%h", k, pc, if_id_instr, if_id_pc4, if_id_valid, 4 * k, 32'h11 * k);
            end
        end
        checks++;
        if (fetch_count !== 32'd4) begin
            errors++; $display("FAIL seq_count got %0d want 4", fetch_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step();
        stall = 1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (pc !== 32'd8 || if_id_instr !== 32'h22 || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold got pc=%h i=%h v=%b want 8/22/1", pc, if_id_instr, if_id_valid);
            end
        end
        stall = 0;
        step();
        checks++;
        if (if_id_instr !== 32'h33 || if_id_pc4 !== 32'd12 || pc !== 32'd12) begin
            errors++;
            $display("FAIL stall_release got i=%h p4=%h pc=%h want 33/c/c", if_id_instr, if_id_pc4, pc);
        end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] cnt0;
        do_reset();
        step(); step();
        cnt0 = fetch_count;
        redirect = 1; redirect_pc = 32'h23; stall = 1;
        step();
        idle_inputs();
        checks++;
        if (pc !== 32'h20 || imem_addr !== 6'd8) begin
            errors++; $display("FAIL redir_pc got pc=%h a=%0d want 20/8", pc, imem_addr);
        end
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || fetch_count !== cnt0) begin
            errors++;
            $display("FAIL redir_bubble got v=%b i=%h c=%0d want 0/0/%0d", if_id_valid, if_id_instr, fetch_count, cnt0);
        end
    endtask

    task automatic test_halt();
        do_reset();
        mem[5] = 32'hFFFF_FFFF;
        repeat (5) step();
        checks++;
        if (pc !== 32'd20 || fetch_count !== 32'd5) begin
            errors++; $display("FAIL halt_pre got pc=%h c=%0d want 14/5", pc, fetch_count);
        end
        // flush/stall must be ignored once halted
        step();
        stall = 1; flush = 1;
        step();
        checks++;
        if (halted !== 1'b1) begin
            errors++; $display("FAIL halt_flag got %b want 1", halted);
        end
        repeat (3) begin
            step();
            checks++;
            if (pc !== 32'd20 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
                fetch_count !== 32'd5 || halted !== 1'b1) begin
                errors++;
                $display("FAIL halt_hold got pc=%h v=%b i=%h c=%0d h=%b want 14/0/0/5/1", pc, if_id_valid, if_id_instr, fetch_count, halted);
            end
        end
        idle_inputs();
        redirect = 1; redirect_pc = 32'h0;
        step();
        idle_inputs();
        checks++;
        if (halted !== 1'b0 || pc !== 32'h0) begin
            errors++; $display("FAIL halt_exit got h=%b pc=%h want 0/0", halted, pc);
        end
        step();
        checks++;
        if (if_id_instr !== 32'h11 || if_id_valid !== 1'b1 || fetch_count !== 32'd6) begin
            errors++;
            $display("FAIL halt_refetch got i=%h v=%b c=%0d want 11/1/6", if_id_instr, if_id_valid, fetch_count);
        end
        mem[5] = 32'h66;
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (7) step();
        checks++;
        if (pc !== 32'h1C || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL areset_pre got pc=%h v=%b want 1c/1", pc, if_id_valid);
        end
        #2 reset = 1;
        #1;
        checks++;
        if (pc !== 32'h0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 ||
            if_id_valid !== 1'b0 || fetch_count !== 32'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL areset got pc=%h i=%h p4=%h v=%b c=%0d h=%b want all 0", pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count, halted);
        end
        @(posedge clk);
        #2 reset = 0;
        model_reset();
    endtask

    task automatic test_wrap();
        do_reset();
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        checks++;
        if (pc !== 32'hFFFF_FFFC || imem_addr !== 6'd63) begin
            errors++; $display("FAIL wrap_tgt got pc=%h a=%0d want fffffffc/63", pc, imem_addr);
        end
        step();
        checks++;
        if (if_id_pc4 !== 32'h0 || pc !== 32'h0 || imem_addr !== 6'd0 ||
            if_id_instr !== mem[63] || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap got p4=%h pc=%h a=%0d i=%h want 0/0/0/%h", if_id_pc4, pc, imem_addr, if_id_instr, mem[63]);
        end
    endtask

    task automatic test_random();
        int bad;
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom | 32'h1;
        do_reset();
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 6) == 0);
            redirect = ($urandom_range(0, 11) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            step();
            checks++;
            if (pc !== m_pc || if_id_instr !== m_instr || if_id_pc4 !== m_pc4 ||
                if_id_valid !== m_valid || halted !== m_halted || fetch_count !== m_cnt) begin
                errors++;
                if (bad < 5)
                    $display("FAIL rand cyc%0d got pc=%h i=%h p4=%h v=%b h=%b c=%0d want pc=%h i=%h p4=%h v=%b h=%b c=%0d", c, pc, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count, m_pc, m_instr, m_pc4, m_valid, m_halted, m_cnt);
                bad++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        fill_mem();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_async_reset();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
